// File: rtl/tlb_walk_sched.sv
// Shared ITLB/DTLB page-table walker: round-robin miss arbitration and
// sequencing of multi-level PTE reads over one memory read port.
module tlb_walk_sched #(
  parameter int XLEN    = 64,
  parameter int PA_BITS = 56,
  parameter int LEVELS  = 3,
  parameter int VPN_SEG = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [PA_BITS-13:0] SATP_PPN,
  input  logic               ITLBMiss,
  input  logic               DTLBMiss,
  input  logic [XLEN-1:0]    IVAdr,
  input  logic [XLEN-1:0]    DVAdr,
  input  logic               TLBFlush,
  output logic               MemReq,
  output logic [PA_BITS-1:0] MemPAdr,
  input  logic               MemAck,
  input  logic [XLEN-1:0]    MemRData,
  output logic [XLEN-1:0]    PTE,
  output logic [1:0]         PageTypeWriteVal,
  output logic               ITLBWrite,
  output logic               DTLBWrite,
  output logic               IWalkFault,
  output logic               DWalkFault,
  output logic               Busy
);

  localparam int VW = LEVELS * VPN_SEG;
  localparam int ZB = (XLEN == 64) ? 3 : 2;
  localparam logic [1:0] LVL_TOP = 2'(LEVELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_FAULT} state_e;

  state_e             state_q;
  logic [1:0]         lvl_q;
  logic [VW-1:0]      vpn_q;
  logic               sel_q;
  logic               last_q;
  logic               abort_q;
  logic               mem_req_q;
  logic [PA_BITS-1:0] mem_padr_q;
  logic [XLEN-1:0]    pte_q;
  logic [1:0]         ptype_q;

  logic          sel_win_s;
  logic [VW-1:0] vpn_win_s;
  logic          miss_sel_s;
  logic          abort_s;
  logic          bad_pte_s;
  logic          leaf_s;
  logic          unused_s;

  function automatic logic [VPN_SEG-1:0] vpn_seg(input logic [VW-1:0] vpn, input logic [1:0] lvl);
    vpn_seg = {VPN_SEG{1'b0}};
    for (int l = 0; l < LEVELS; l++) begin
      if (int'(lvl) == l) vpn_seg = vpn[l*VPN_SEG +: VPN_SEG];
    end
  endfunction

  assign sel_win_s  = (ITLBMiss & DTLBMiss) ? ~last_q : DTLBMiss;
  assign vpn_win_s  = sel_win_s ? DVAdr[12 +: VW] : IVAdr[12 +: VW];
  assign miss_sel_s = sel_q ? DTLBMiss : ITLBMiss;
  // Abort includes the condition arising this very cycle, not just the sticky flag.
  assign abort_s    = abort_q | TLBFlush | ~miss_sel_s;
  assign bad_pte_s  = ~MemRData[0] | (MemRData[2] & ~MemRData[1]);
  assign leaf_s     = MemRData[1] | MemRData[3];
  assign unused_s   = ^{IVAdr, DVAdr};

  // Walk state machine with registered memory request, address and leaf data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      lvl_q      <= 2'd0;
      vpn_q      <= {VW{1'b0}};
      sel_q      <= 1'b0;
      last_q     <= 1'b0;
      abort_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_padr_q <= {PA_BITS{1'b0}};
      pte_q      <= {XLEN{1'b0}};
      ptype_q    <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ITLBMiss | DTLBMiss) begin
            sel_q      <= sel_win_s;
            last_q     <= sel_win_s;
            vpn_q      <= vpn_win_s;
            lvl_q      <= LVL_TOP;
            abort_q    <= 1'b0;
            mem_padr_q <= {SATP_PPN, vpn_seg(vpn_win_s, LVL_TOP), {ZB{1'b0}}};
            mem_req_q  <= 1'b1;
            state_q    <= S_READ;
          end
        end
        S_READ: begin
          if (MemAck) begin
            if (abort_s) begin
              mem_req_q <= 1'b0;
              state_q   <= S_IDLE;
            end else if (bad_pte_s) begin
              mem_req_q <= 1'b0;
              state_q   <= S_FAULT;
            end else if (leaf_s) begin
              mem_req_q <= 1'b0;
              pte_q     <= MemRData;
              ptype_q   <= lvl_q;
              state_q   <= S_WRITE;
            end else if (lvl_q == 2'd0) begin
              mem_req_q <= 1'b0;
              state_q   <= S_FAULT;
            end else begin
              lvl_q      <= lvl_q - 2'd1;
              mem_padr_q <= {MemRData[PA_BITS-3:10], vpn_seg(vpn_q, lvl_q - 2'd1), {ZB{1'b0}}};
            end
          end else begin
            abort_q <= abort_s;
          end
        end
        S_WRITE, S_FAULT: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign MemReq           = mem_req_q;
  assign MemPAdr          = mem_padr_q;
  assign PTE              = pte_q;
  assign PageTypeWriteVal = ptype_q;
  assign Busy             = (state_q != S_IDLE);
  assign ITLBWrite        = (state_q == S_WRITE) & ~sel_q & ~abort_s;
  assign DTLBWrite        = (state_q == S_WRITE) &  sel_q & ~abort_s;
  assign IWalkFault       = (state_q == S_FAULT) & ~sel_q & ~abort_s;
  assign DWalkFault       = (state_q == S_FAULT) &  sel_q & ~abort_s;

endmodule

// File: tb/tb_tlb_walk_sched.sv
// Directed bench for tlb_walk_sched: table of Sv39 walks plus hand-written
// tie, flush and reset sequences against a simple PTE memory responder.
module tb_tlb_walk_sched;

  logic        clk;
  logic        reset_n;
  logic [43:0] SATP_PPN;
  logic        ITLBMiss, DTLBMiss, TLBFlush;
  logic [63:0] IVAdr, DVAdr;
  logic        MemReq, MemAck;
  logic [55:0] MemPAdr;
  logic [63:0] MemRData, PTE;
  logic [1:0]  PageTypeWriteVal;
  logic        ITLBWrite, DTLBWrite, IWalkFault, DWalkFault, Busy;

  int errors = 0;
  int checks = 0;

  tlb_walk_sched dut (
    .clk(clk), .reset_n(reset_n), .SATP_PPN(SATP_PPN),
    .ITLBMiss(ITLBMiss), .DTLBMiss(DTLBMiss), .IVAdr(IVAdr), .DVAdr(DVAdr),
    .TLBFlush(TLBFlush), .MemReq(MemReq), .MemPAdr(MemPAdr), .MemAck(MemAck),
    .MemRData(MemRData), .PTE(PTE), .PageTypeWriteVal(PageTypeWriteVal),
    .ITLBWrite(ITLBWrite), .DTLBWrite(DTLBWrite), .IWalkFault(IWalkFault),
    .DWalkFault(DWalkFault), .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: acks after mlat waiting cycles, logs every read address.
  int          mlat = 0;
  int          mbase = 0;
  int          midx = 0;
  int          mwait = 0;
  logic [63:0] mdata [4];
  logic [55:0] maddr [64];

  always @(negedge clk) begin
    MemAck = 1'b0;
    if (MemReq) begin
      if (mwait >= mlat) begin
        MemAck = 1'b1;
        MemRData = ((midx - mbase) >= 0 && (midx - mbase) < 4) ? mdata[midx - mbase] : 64'h0;
        if (midx < 64) maddr[midx] = MemPAdr;
        midx++;
        mwait = 0;
      end else begin
        mwait++;
      end
    end else begin
      mwait = 0;
    end
  end

  typedef struct {
    logic        is_d;
    logic [63:0] vadr;
    int          lat;
    int          n;
    logic [63:0] d [3];
    logic [55:0] a [3];
    logic        fault;
    logic [1:0]  ptype;
    logic [63:0] pte;
    logic        flush;
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mk(input logic is_d, input logic [63:0] vadr, input int lat, input int n,
                              input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                              input logic [55:0] a0, input logic [55:0] a1, input logic [55:0] a2,
                              input logic fault, input logic [1:0] pt, input logic [63:0] pte,
                              input logic flush);
    vec_t v;
    v.is_d = is_d; v.vadr = vadr; v.lat = lat; v.n = n;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
    v.fault = fault; v.ptype = pt; v.pte = pte; v.flush = flush;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {ITLBWrite, DTLBWrite, IWalkFault, DWalkFault};
  endfunction

  task automatic wait_strobe(input int maxc, output logic [3:0] stb, output int cyc);
    stb = 4'b0000;
    cyc = 0;
    while (stb == 4'b0000 && cyc < maxc) begin
      @(posedge clk); #1;
      cyc++;
      stb = strobes();
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; ITLBMiss = 1'b0; DTLBMiss = 1'b0; TLBFlush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [3:0] stb, exp_stb;
    int cyc, base, off;
    logic [63:0] pte_s;
    logic [1:0] pt_s;
    mlat = v.lat;
    for (int i = 0; i < 3; i++) mdata[i] = v.d[i];
    mdata[3] = 64'h0;
    mbase = midx;
    base = midx;
    off = 0;
    if (v.is_d) begin DVAdr = v.vadr; DTLBMiss = 1'b1; end
    else begin IVAdr = v.vadr; ITLBMiss = 1'b1; end
    if (v.flush) begin
      TLBFlush = 1'b1;
      @(posedge clk); #1;
      TLBFlush = 1'b0;
      off = 1;
    end
    wait_strobe(60, stb, cyc);
    pte_s = PTE;
    pt_s = PageTypeWriteVal;
    exp_stb = v.fault ? (v.is_d ? 4'b0001 : 4'b0010) : (v.is_d ? 4'b0100 : 4'b1000);
    chk({tag, "_strobe"}, {60'h0, stb}, {60'h0, exp_stb});
    chk({tag, "_latency"}, 64'(cyc + off), 64'(v.n * (v.lat + 1) + 1));
    chk({tag, "_reads"}, 64'(midx - base), 64'(v.n));
    for (int i = 0; i < v.n; i++)
      chk($sformatf("%s_addr%0d", tag, i), {8'h0, maddr[base + i]}, {8'h0, v.a[i]});
    if (!v.fault) begin
      chk({tag, "_pte"}, pte_s, v.pte);
      chk({tag, "_ptype"}, {62'h0, pt_s}, {62'h0, v.ptype});
    end
    @(posedge clk); #1;
    chk({tag, "_after"}, {59'h0, strobes(), Busy}, 64'h0);
    ITLBMiss = 1'b0;
    DTLBMiss = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] stb;
    int cyc, base, hi;
    logic [3:0] stb_any;

    SATP_PPN = 44'h80000;
    ITLBMiss = 1'b0; DTLBMiss = 1'b0; TLBFlush = 1'b0;
    IVAdr = 64'h0; DVAdr = 64'h0;
    reset_n = 1'b0;
    #2;
    chk("rst_memreq", {63'h0, MemReq}, 64'h0);
    chk("rst_mempadr", {8'h0, MemPAdr}, 64'h0);
    chk("rst_pte", PTE, 64'h0);
    chk("rst_ptype", {62'h0, PageTypeWriteVal}, 64'h0);
    chk("rst_strobes", {60'h0, strobes()}, 64'h0);
    chk("rst_busy", {63'h0, Busy}, 64'h0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    vecs[0] = mk(1'b0, 64'h4020_1000, 1, 3, 64'h2000_0401, 64'h2000_0801, 64'h2000_40CF,
                 56'h8000_0008, 56'h8000_1008, 56'h8000_2008, 1'b0, 2'd0, 64'h2000_40CF, 1'b0);
    vecs[1] = mk(1'b0, 64'h4020_1000, 1, 1, 64'h2000_00CF, 64'h0, 64'h0,
                 56'h8000_0008, 56'h0, 56'h0, 1'b0, 2'd2, 64'h2000_00CF, 1'b0);
    vecs[2] = mk(1'b1, 64'h4020_1000, 1, 2, 64'h2000_0401, 64'h0, 64'h0,
                 56'h8000_0008, 56'h8000_1008, 56'h0, 1'b1, 2'd0, 64'h0, 1'b0);
    vecs[3] = mk(1'b0, 64'h4020_1000, 0, 1, 64'h2000_0005, 64'h0, 64'h0,
                 56'h8000_0008, 56'h0, 56'h0, 1'b1, 2'd0, 64'h0, 1'b0);
    vecs[4] = mk(1'b0, 64'h4020_1000, 1, 3, 64'h2000_0401, 64'h2000_0801, 64'h2000_0C01,
                 56'h8000_0008, 56'h8000_1008, 56'h8000_2008, 1'b1, 2'd0, 64'h0, 1'b0);
    vecs[5] = mk(1'b1, 64'h0060_3000, 0, 2, 64'h2000_0401, 64'h2000_04CB, 64'h0,
                 56'h8000_0000, 56'h8000_1018, 56'h0, 1'b0, 2'd1, 64'h2000_04CB, 1'b0);
    vecs[6] = mk(1'b0, 64'h4020_1000, 2, 1, 64'h2000_0009, 64'h0, 64'h0,
                 56'h8000_0008, 56'h0, 56'h0, 1'b0, 2'd2, 64'h2000_0009, 1'b1);

    for (int k = 0; k < 7; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Flush while the first read is outstanding: read completes, walk is dropped.
    mlat = 3;
    mdata[0] = 64'h2000_0401; mdata[1] = 64'h2000_0801; mdata[2] = 64'h2000_40CF; mdata[3] = 64'h0;
    mbase = midx; base = midx;
    IVAdr = 64'h4020_1000; ITLBMiss = 1'b1;
    @(posedge clk); #1;
    TLBFlush = 1'b1;
    hi = MemReq ? 1 : 0;
    stb_any = strobes();
    cyc = 0;
    while (midx == base && cyc < 20) begin
      @(posedge clk); #1;
      TLBFlush = 1'b0;
      cyc++;
      if (MemReq) hi++;
      stb_any |= strobes();
    end
    chk("flush_busy_after_ack", {62'h0, Busy, MemReq}, 64'h0);
    ITLBMiss = 1'b0;
    chk("flush_req_held", 64'(hi), 64'd4);
    chk("flush_reads", 64'(midx - base), 64'd1);
    @(posedge clk); #1;
    stb_any |= strobes();
    chk("flush_no_strobe", {60'h0, stb_any}, 64'h0);

    // Tie after reset: D first; D still requesting at the next IDLE makes a second tie, won by I.
    do_reset();
    mlat = 0;
    for (int i = 0; i < 4; i++) mdata[i] = 64'h2000_00CF;
    mbase = midx;
    IVAdr = 64'h4020_1000; DVAdr = 64'h4020_1000;
    ITLBMiss = 1'b1; DTLBMiss = 1'b1;
    wait_strobe(20, stb, cyc);
    chk("tie1_d_first", {60'h0, stb}, 64'h4);
    chk("tie1_latency", 64'(cyc), 64'd2);
    @(posedge clk); #1;
    chk("tie_idle_gap", {63'h0, Busy}, 64'h0);
    @(posedge clk); #1;
    DTLBMiss = 1'b0;
    wait_strobe(20, stb, cyc);
    chk("tie2_i_next", {60'h0, stb}, 64'h8);
    chk("tie2_latency", 64'(cyc), 64'd1);
    @(posedge clk); #1;
    ITLBMiss = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a read.
    mlat = 3;
    mbase = midx;
    IVAdr = 64'h4020_1000; ITLBMiss = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstmid_req_before", {62'h0, MemReq, Busy}, 64'h3);
    #1 reset_n = 1'b0;
    #1;
    chk("rstmid_immediate", {58'h0, MemReq, Busy, strobes()}, 64'h0);
    ITLBMiss = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_idle", {62'h0, MemReq, Busy}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlb_walk_sched.md
# tlb_walk_sched

Shared hardware page-table walker and scheduler for the instruction and data TLBs. It arbitrates ITLB and DTLB misses round-robin, then sequences the multi-level PTE reads over a single memory read port. It delivers a leaf PTE and page type to the requesting TLB's fill port, or raises a walk fault to that requester. It sits between the two TLBs and the memory arbiter in the MMU.

## Interface
Parameters:
- XLEN, 64, datapath and PTE width; 32 selects Sv32, 64 selects Sv39.
- PA_BITS, 56, physical address width (34 for XLEN=32).
- LEVELS, 3, page-table levels (2 for Sv32).
- VPN_SEG, 9, bits per VPN segment (10 for Sv32).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- SATP_PPN  in  PA_BITS-12  root page-table PPN.
- ITLBMiss, DTLBMiss  in  1  miss requests, level-held while the miss persists.
- IVAdr, DVAdr  in  XLEN  missing virtual addresses.
- TLBFlush  in  1  sfence/satp-change flush.
- MemReq  out  1  PTE read request.
- MemPAdr  out  PA_BITS  PTE physical address.
- MemAck  in  1  read complete; MemRData valid this cycle.
- MemRData  in  XLEN  PTE read data.
- PTE  out  XLEN  registered leaf PTE to both TLBs.
- PageTypeWriteVal  out  2  leaf level: 0 = 4 KiB, 1 = mega, 2 = giga.
- ITLBWrite, DTLBWrite  out  1  one-cycle fill strobes.
- IWalkFault, DWalkFault  out  1  one-cycle page-fault strobes.
- Busy  out  1  walk in progress (state != IDLE).

## Operation
- States: IDLE, READ, WRITE, FAULT.
- Level counter Lvl has width 2. Latched VPN register holds LEVELS*VPN_SEG bits. Grant flag Sel: 0 = I, 1 = D. Sticky Abort flag.
- Arbitration happens in IDLE on (ITLBMiss | DTLBMiss).
  - Single requester wins.
  - When both request, the requester not granted last wins. LastGrant resets to I, so D wins the first tie.
- Grant actions:
  - Latch Sel and the VPN of the winner's VAdr[12 +: LEVELS*VPN_SEG].
  - Set Lvl = LEVELS-1 and clear Abort.
  - Load the address register with {SATP_PPN, VPN[Lvl], zeros}. zeros is 3 bits for XLEN=64 and 2 bits for XLEN=32.
  - Go to READ.
- READ: MemReq=1 and MemPAdr is held stable until the MemAck cycle. On MemAck, MemRData is decoded with V=[0], R=[1], W=[2], X=[3]:
  - If V=0, or W=1 with R=0: go to FAULT.
  - If R|X (leaf): register PTE=MemRData and PageTypeWriteVal=Lvl, then go to WRITE.
  - Otherwise (pointer) with Lvl=0: go to FAULT.
  - Otherwise (pointer) with Lvl>0: Lvl--, address = {MemRData[PA_BITS-3:10], VPN[Lvl-1], zeros}, stay in READ.
- Superpage misalignment and A/D checks are not done here; the TLB performs them on the filled entry.
- WRITE: pulse ITLBWrite (Sel=0) or DTLBWrite (Sel=1) for one cycle, then go to IDLE.
- FAULT: pulse IWalkFault or DWalkFault for one cycle, then go to IDLE.
- Abort:
  - Abort is set in any non-IDLE cycle where TLBFlush=1 or the granted requester's Miss=0.
  - An in-flight read is never cancelled. MemReq stays high until MemAck.
  - On MemAck with Abort set (or setting that cycle), go to IDLE.
  - In WRITE/FAULT with Abort set (or setting that cycle), the strobe is suppressed.
- TLBFlush in IDLE has no effect. A miss present in the same cycle as the flush is still granted.

## Timing
- Reset values: MemReq=0, MemPAdr=0, PTE=0, PageTypeWriteVal=0, all strobes 0, Busy=0. State=IDLE, LastGrant=I.
- Reset is asynchronous: asserting reset_n mid-walk forces MemReq=0 and strobes=0 immediately, with no completion.
- A miss seen in IDLE at cycle t gives MemReq=1 at t+1.
- The memory may ack in the same cycle as the request; the minimum read is 1 cycle.
- The next-level MemReq is asserted the cycle after MemAck, with the new MemPAdr. MemReq stays continuously high across levels.
- The leaf strobe occurs the cycle after the final MemAck; IDLE follows.
- With 1-cycle acks, a full Sv39 walk takes 5 cycles from grant to strobe (1 + 3 reads + 1). The earliest next grant is the cycle after the strobe.
- Requesters must drop Miss within 1 cycle of the fill strobe; otherwise a re-walk is granted.

## Test plan
- Sv39 4 KiB walk:
  - Setup: SATP_PPN=0x80000, IVAdr=0x4020_1000, acks 1 cycle after request.
  - Reads and returns:
    - MemPAdr 0x8000_0008 returns 0x2000_0401.
    - MemPAdr 0x8000_1008 returns 0x2000_0801.
    - MemPAdr 0x8000_2008 returns 0x2000_40CF.
  - Required: ITLBWrite pulses 1 cycle with PTE=0x2000_40CF, PageTypeWriteVal=0.
- Gigapage: same setup, first read returns 0x2000_00CF. Required: one read only, ITLBWrite pulses with PageTypeWriteVal=2.
- Tie after reset:
  - Stimulus: ITLBMiss=DTLBMiss=1 in the same cycle.
  - Required: the D walk completes first with DTLBWrite; I is granted the cycle after.
  - Follow-up: a second tie grants I first.
- Faults:
  - Stimulus: level-1 PTE=0x0 (V=0), with the D requester granted. Required: DWalkFault pulses 1 cycle and DTLBWrite stays 0.
  - Stimulus: a PTE with W=1, R=0. Required: fault.
  - Stimulus: a pointer PTE at Lvl=0. Required: fault.
- Flush mid-read:
  - Stimulus: pulse TLBFlush while MemReq=1 and no ack has arrived.
  - Required: MemReq stays high until MemAck, no strobe occurs, and Busy=0 the cycle after the ack.
- Reset mid-walk: assert reset_n=0 during READ. Required: MemReq=0 and Busy=0 within the same cycle, before the next clock edge.
